// File: rtl/song_pkg.sv
// Shared definitions for the song player: note-word layout, end marker and FSM states.
package song_pkg;

  localparam int PITCH_LSB = 16;
  localparam int PITCH_W   = 16;
  localparam int DUR_LSB   = 0;
  localparam int DUR_W     = 16;

  localparam logic [DUR_W-1:0] END_DURATION = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    PLAY,
    PAUSED
  } state_e;

  function automatic logic [PITCH_W-1:0] get_pitch(input logic [31:0] word);
    return word[PITCH_LSB +: PITCH_W];
  endfunction

  function automatic logic [DUR_W-1:0] get_dur(input logic [31:0] word);
    return word[DUR_LSB +: DUR_W];
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Emits a single-cycle tick after every TICK_DIV enabled cycles; clear restarts the count.
module tick_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/song_player_ctrl.sv
// Song player: fetches note words from song memory and presents each pitch for
// duration*TICK_DIV cycles, with pause, stop and loop-on-end-marker control.
module song_player_ctrl
  import song_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int TICK_DIV = 100000
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              note_valid,
  output logic [15:0]       note_pitch,
  output logic              busy,
  output logic              done
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [PITCH_W-1:0] pitch_q, pitch_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               presc_clr, presc_en, tick;
  logic [DUR_W-1:0]   rd_dur;

  assign rd_dur   = get_dur(mem_rdata);
  assign presc_en = (state_q == PLAY) && !stop;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk_i  (ACLK),
    .rst_ni (ARESETN),
    .clear_i(presc_clr),
    .en_i   (presc_en),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    base_d    = base_q;
    dur_d     = dur_q;
    pitch_d   = pitch_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    presc_clr = 1'b0;
    if (stop) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_d  = base_addr;
            base_d  = base_addr;
            state_d = FETCH;
          end
        end
        FETCH: state_d = WAIT;
        WAIT: begin
          if (rd_dur != END_DURATION) begin
            pitch_d   = get_pitch(mem_rdata);
            dur_d     = rd_dur;
            presc_clr = 1'b1;
            valid_d   = 1'b1;
            state_d   = PLAY;
          end else if (loop_en && (addr_q != base_q)) begin
            addr_d  = base_q;
            state_d = FETCH;
          end else begin
            done_d  = 1'b1;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        PLAY: begin
          if (tick) dur_d = dur_q - DUR_W'(1);
          // The final tick wins over pause so a paused note never resumes at zero.
          if (tick && (dur_q == DUR_W'(1))) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = FETCH;
          end else if (pause) begin
            state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (!pause) state_d = PLAY;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      dur_q   <= '0;
      pitch_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      dur_q   <= dur_d;
      pitch_q <= pitch_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign mem_en     = (state_q == FETCH);
  assign mem_addr   = addr_q;
  assign note_valid = valid_q && (state_q != PAUSED);
  assign note_pitch = pitch_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_song_player_ctrl.sv
// Directed bench for song_player_ctrl with TICK_DIV=4 and a 1024-word song memory.
module tb_song_player_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        note_valid;
  logic [15:0] note_pitch;
  logic        busy, done;

  logic [31:0] mem [0:1023];

  int n_tests = 0, n_fail = 0;
  int reads[$];
  int done_cnt, play1, play2, low_cnt;
  bit seen_valid, men_prev;
  logic [15:0] p1, p2;

  typedef struct {
    int          base;
    logic [31:0] w0, w1, w2;
    logic        loop;
    int          pause_at, pause_len, bstart_at;
    int          exp_n;
    int          ea0, ea1, ea2;
    int          exp_done, exp_p1, exp_p2, exp_low;
  } row_t;

  row_t tbl[5];

  song_player_ctrl #(.ADDR_W(10), .TICK_DIV(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .stop(stop), .pause(pause),
    .loop_en(loop_en), .base_addr(base_addr), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .note_valid(note_valid), .note_pitch(note_pitch),
    .busy(busy), .done(done)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) if (mem_en) mem_rdata <= mem[mem_addr];

  always @(negedge ACLK) begin
    if (mem_en) reads.push_back(int'(mem_addr));
    if (done) done_cnt++;
    if (note_valid && !mem_en && !men_prev) begin
      if (note_pitch == p1) play1++;
      else if (note_pitch == p2) play2++;
    end
    if (note_valid) seen_valid = 1'b1;
    else if (seen_valid && busy) low_cnt++;
    men_prev = mem_en;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    reads.delete();
    done_cnt = 0; play1 = 0; play2 = 0; low_cnt = 0;
    seen_valid = 1'b0; men_prev = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ACLK); #1;
    end
  endtask

  task automatic load_song(input int base, input logic [31:0] w0, w1, w2);
    mem[base % 1024]       = w0;
    mem[(base + 1) % 1024] = w1;
    mem[(base + 2) % 1024] = w2;
    p1 = w0[31:16];
    p2 = w1[31:16];
  endtask

  task automatic wait_valid(input string nm);
    int c;
    c = 0;
    while (!note_valid && c < 100) begin
      @(posedge ACLK); #1;
      c++;
    end
    chk({nm, "_timeout"}, note_valid, 1'b1);
  endtask

  task automatic run_row(input row_t r, input int idx);
    int k;
    bit fin;
    int ea[3];
    load_song(r.base, r.w0, r.w1, r.w2);
    clear_stats();
    ea[0] = r.ea0; ea[1] = r.ea1; ea[2] = r.ea2;
    @(posedge ACLK); #1;
    base_addr = 10'(r.base); loop_en = r.loop; start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    chk($sformatf("r%0d_start_mem_en", idx), mem_en, 1'b1);
    chk($sformatf("r%0d_start_addr", idx), mem_addr, r.base);
    k = 0; fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(posedge ACLK); #1;
      if (seen_valid) k++;
      pause = (r.pause_len > 0) && (k >= r.pause_at) && (k < r.pause_at + r.pause_len);
      start = (k == r.bstart_at);
      if (start) base_addr = 10'(r.base + 300);
      if (!busy) fin = 1'b1;
    end
    pause = 1'b0; start = 1'b0; loop_en = 1'b0;
    chk($sformatf("r%0d_end_timeout", idx), fin, 1'b1);
    @(negedge ACLK); #1;
    chk($sformatf("r%0d_nreads", idx), reads.size(), r.exp_n);
    for (int i = 0; i < r.exp_n && i < 3; i++)
      if (i < reads.size()) chk($sformatf("r%0d_read%0d", idx, i), reads[i], ea[i]);
    chk($sformatf("r%0d_done_cnt", idx), done_cnt, r.exp_done);
    chk($sformatf("r%0d_play1", idx), play1, r.exp_p1);
    chk($sformatf("r%0d_play2", idx), play2, r.exp_p2);
    chk($sformatf("r%0d_low", idx), low_cnt, r.exp_low);
    chk($sformatf("r%0d_valid_end", idx), note_valid, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    //        base  w0            w1            w2  loop pat plen bst  n  a0   a1 a2 done p1 p2 low
    tbl[0] = '{0,    32'h0100_0002, 32'h0200_0001, 0, 0, 0, 0, -1, 3, 0,    1, 2, 1, 8, 4, 0};
    tbl[1] = '{0,    32'h0100_0002, 32'h0200_0001, 0, 0, 2, 5, -1, 3, 0,    1, 2, 1, 8, 4, 5};
    tbl[2] = '{1023, 32'h0300_0001, 32'h0400_0001, 0, 0, 0, 0, -1, 3, 1023, 0, 1, 1, 4, 4, 0};
    tbl[3] = '{5,    32'h0000_0000, 32'h0000_0000, 0, 1, 0, 0, -1, 1, 5,    0, 0, 1, 0, 0, 0};
    tbl[4] = '{0,    32'h0100_0002, 32'h0200_0001, 0, 0, 0, 0, 3,  3, 0,    1, 2, 1, 8, 4, 0};

    clear_stats();
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_valid", note_valid, 1'b0);
    chk("rst_pitch", note_pitch, 0);
    chk("rst_done", done, 1'b0);
    cycles(2);
    ARESETN = 1'b1;
    cycles(1);

    for (int i = 0; i < 5; i++) run_row(tbl[i], i);

    // Looping two-note song: reads cycle through 0,1,2 with no done, then stop.
    load_song(0, 32'h0500_0001, 32'h0600_0001, 32'h0000_0000);
    clear_stats();
    base_addr = 10'd0; loop_en = 1'b1; start = 1'b1;
    cycles(1);
    start = 1'b0;
    for (int c = 0; c < 300 && reads.size() < 7; c++) cycles(1);
    chk("loop_nreads", reads.size() >= 7, 1'b1);
    for (int i = 0; i < 7 && i < reads.size(); i++)
      chk($sformatf("loop_read%0d", i), reads[i], i % 3);
    chk("loop_no_done", done_cnt, 0);
    chk("loop_busy", busy, 1'b1);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0; loop_en = 1'b0;
    chk("loop_stop_busy", busy, 1'b0);
    chk("loop_stop_valid", note_valid, 1'b0);
    cycles(3);
    chk("loop_stop_no_done", done_cnt, 0);

    // Latency from start, then stop during PLAY.
    load_song(0, 32'h0100_0002, 32'h0200_0001, 32'h0000_0000);
    clear_stats();
    base_addr = 10'd0; start = 1'b1;
    cycles(1);
    start = 1'b0;
    chk("lat_mem_en", mem_en, 1'b1);
    cycles(1);
    chk("lat_wait_valid", note_valid, 1'b0);
    cycles(1);
    chk("lat_play_valid", note_valid, 1'b1);
    chk("lat_play_pitch", note_pitch, 16'h0100);
    cycles(2);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    chk("stop_busy", busy, 1'b0);
    chk("stop_valid", note_valid, 1'b0);
    cycles(4);
    chk("stop_no_done", done_cnt, 0);
    chk("stop_nreads", reads.size(), 1);

    // Start and stop together leave the block idle.
    start = 1'b1; stop = 1'b1;
    cycles(1);
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 1'b0);
    chk("startstop_mem_en", mem_en, 1'b0);

    // Asynchronous reset mid-PLAY, then replay from base.
    base_addr = 10'd0; start = 1'b1;
    cycles(1);
    start = 1'b0;
    wait_valid("rstplay");
    cycles(2);
    ARESETN = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_valid", note_valid, 1'b0);
    chk("arst_pitch", note_pitch, 0);
    chk("arst_mem_en", mem_en, 1'b0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_done", done, 1'b0);
    cycles(1);
    ARESETN = 1'b1;
    run_row(tbl[0], 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/song_player_ctrl.md
SONG_PLAYER_CTRL -- requirements
Module: song_player_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, song memory word-address width.
REQ-002 SHALL have parameter TICK_DIV, default 100000, ACLK cycles per duration tick (1 ms at 100 MHz).
REQ-003 SHALL have port ACLK  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  begin playback from base_addr; sampled in IDLE only.
REQ-006 SHALL have port stop  in  1  abort playback.
REQ-007 SHALL have port pause  in  1  level; freeze the current note while high.
REQ-008 SHALL have port loop_en  in  1  restart at base_addr on the end marker.
REQ-009 SHALL have port base_addr  in  ADDR_W  first note word address; sampled on start.
REQ-010 SHALL have port mem_en  out  1  song memory read strobe.
REQ-011 SHALL have port mem_addr  out  ADDR_W  song memory read address.
REQ-012 SHALL have port mem_rdata  in  32  read data, valid exactly 1 cycle after mem_en.
REQ-013 SHALL have port note_valid  out  1  note_pitch is meaningful.
REQ-014 SHALL have port note_pitch  out  16  pitch code for the tone generator.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port done  out  1  single-cycle pulse at natural song end.

Function
REQ-017 Note word SHALL be [31:16] pitch, [15:0] duration in ticks; duration 0 SHALL be the end marker.
REQ-018 FSM SHALL have states IDLE, FETCH, WAIT, PLAY, PAUSED.
REQ-019 IDLE with start=1 SHALL latch addr=base_addr and go to FETCH.
REQ-020 FETCH SHALL drive mem_en=1 and mem_addr=addr for exactly one cycle, then go to WAIT.
- mem_en SHALL be 0 in all other states.
REQ-021 WAIT with a non-zero duration SHALL:
- latch pitch into note_pitch;
- load dur_cnt with the duration;
- clear the tick prescaler;
- set note_valid=1;
- go to PLAY.
REQ-022 WAIT with the end marker and loop_en=0 SHALL pulse done, clear note_valid, and go to IDLE.
REQ-023 WAIT with the end marker and loop_en=1 SHALL set addr=base_addr and go to FETCH.
- Exception: if the marker address equals base_addr (empty song), it SHALL pulse done and go to IDLE.
REQ-024 PLAY SHALL decrement dur_cnt once per TICK_DIV cycles.
- On the tick that takes dur_cnt to 0, it SHALL set addr=addr+1 and go to FETCH.
- PLAY SHALL therefore last exactly duration*TICK_DIV cycles.
REQ-025 addr increment SHALL wrap modulo 2^ADDR_W.
REQ-026 note_valid and note_pitch SHALL hold their values through the FETCH/WAIT gap between consecutive notes.
REQ-027 PLAY with pause=1 SHALL go to PAUSED.
- PAUSED SHALL freeze the prescaler and dur_cnt and force note_valid=0.
- pause=0 SHALL return to PLAY with note_valid=1 and the count unchanged.
REQ-028 stop=1 in any state SHALL force IDLE on the next edge with note_valid=0 and no done pulse.
- Priority SHALL be stop > pause > start.
REQ-029 start outside IDLE SHALL be ignored; start and stop in the same cycle SHALL leave the block in IDLE.
REQ-030 Latency SHALL be:
- start to mem_en: 1 cycle;
- mem_en to note_valid: 2 cycles.

Reset
REQ-031 ARESETN low SHALL immediately force the following, including mid-playback:
- state=IDLE; addr=0; dur_cnt=0; prescaler=0;
- mem_en=0; mem_addr=0; note_valid=0; note_pitch=0; busy=0; done=0.
REQ-032 Operation SHALL resume on the first ACLK edge after deassertion; deassertion SHALL be synchronized externally.

Structure
REQ-033 Shared package song_pkg SHALL hold:
- the note-word field positions and widths;
- the END_DURATION constant (0);
- the FSM state enum.
REQ-034 Sub-module tick_prescaler SHALL be used: it takes clear/enable inputs and produces a single-cycle tick every TICK_DIV enabled cycles.

Verification (TICK_DIV=4)
REQ-035 Mem[0..2] = 0x0100_0002, 0x0200_0001, 0x0000_0000; start with base 0 -> expected response:
- pitch 0x0100 valid 8 PLAY cycles;
- then 0x0200 for 4 cycles;
- done pulses once; busy falls.
REQ-036 Same song, pause high 5 cycles during first note -> expected response:
- note_valid low 5 cycles;
- first note PLAY total still 8 cycles;
- reads at addr 0,1,2 only.
REQ-037 loop_en=1, two-note song -> expected response:
- mem_addr sequence 0,1,2,0,1,2,...; no done.
- Separately, marker at base_addr with loop_en=1 -> done after one read, IDLE.
REQ-038 base_addr=1023, notes at 1023 and 0, marker at 1 -> expected response: reads 1023, 0, 1 (wrap); done.
REQ-039 stop during PLAY -> expected response: IDLE next cycle, note_valid=0, no done.
- Start while busy -> expected response: ignored.
REQ-040 ARESETN low mid-PLAY -> expected response: all outputs 0 immediately; new start replays from base_addr.
